// File: rtl/sig_debounce_sync_if.sv
// Level-conditioning bundle: noisy input and sample strobe in, clean level and edge strobes out.
interface sig_debounce_sync_if;
  logic raw;
  logic sample_en;
  logic sig;
  logic rise;
  logic fall;

  modport master (output raw, output sample_en, input sig, input rise, input fall);
  modport slave  (input raw, input sample_en, output sig, output rise, output fall);
endinterface

// File: rtl/sig_debounce_sync.sv
// Synchronises an asynchronous bouncy level and debounces it with a stability-counting FSM,
// producing a registered clean level plus single-cycle rise/fall strobes.
module sig_debounce_sync #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                clock,
  input  logic                reset,
  sig_debounce_sync_if.slave  dbi
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_LOW      = 2'd0,
    ST_RISE_CHK = 2'd1,
    ST_HIGH     = 2'd2,
    ST_FALL_CHK = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   sig_q, sig_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  // The synchroniser is the only load on raw, so metastability/X never reaches the FSM directly.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], dbi.raw};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (dbi.sample_en) begin
      case (state_q)
        ST_LOW: begin
          if (s) begin
            state_d = ST_RISE_CHK;
            cnt_d   = CNT_ONE;
          end
        end
        ST_RISE_CHK: begin
          if (!s) begin
            state_d = ST_LOW;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_HIGH;
            sig_d   = 1'b1;
            rise_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_HIGH: begin
          if (!s) begin
            state_d = ST_FALL_CHK;
            cnt_d   = CNT_ONE;
          end
        end
        ST_FALL_CHK: begin
          if (s) begin
            state_d = ST_HIGH;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_LOW;
            sig_d   = 1'b0;
            fall_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_LOW;
      cnt_q   <= '0;
      sig_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign dbi.sig  = sig_q;
  assign dbi.rise = rise_q;
  assign dbi.fall = fall_q;

endmodule

// File: tb/tb_sig_debounce_sync.sv
// Bench for sig_debounce_sync: directed scenarios with fixed edge expectations plus a randomized
// bouncy-input run, all compared against a run-length reference model of the debounce rule.
module tb_sig_debounce_sync;

  localparam int SYNC_STAGES   = 2;
  localparam int STABLE_CYCLES = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  sig_debounce_sync_if dbi ();

  sig_debounce_sync #(
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) dut (
    .clock(clock),
    .reset(reset),
    .dbi  (dbi)
  );

  always #5 clock = ~clock;

  // Reference: raw is seen SYNC_STAGES edges late; the level flips once STABLE_CYCLES consecutive
  // enabled samples disagree with it, and any agreeing enabled sample restarts the run.
  bit m_hist [SYNC_STAGES];
  int m_run  = 0;
  bit m_sig  = 1'b0;
  bit m_rise = 1'b0;
  bit m_fall = 1'b0;

  always @(posedge clock) begin
    bit s_now;
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) m_hist[i] = 1'b0;
      m_run  = 0;
      m_sig  = 1'b0;
      m_rise = 1'b0;
      m_fall = 1'b0;
    end else begin
      s_now  = m_hist[SYNC_STAGES-1];
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (dbi.sample_en) begin
        if (s_now != m_sig) begin
          m_run = m_run + 1;
          if (m_run == STABLE_CYCLES) begin
            m_sig  = s_now;
            m_rise = s_now;
            m_fall = !s_now;
            m_run  = 0;
          end
        end else begin
          m_run = 0;
        end
      end
      for (int i = SYNC_STAGES - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = dbi.raw;
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  // Brings the DUT to a settled LOW state with raw low.
  task automatic go_low();
    dbi.raw       = 1'b0;
    dbi.sample_en = 1'b1;
    reset         = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    dbi.raw       = 1'b1;
    dbi.sample_en = 1'b1;
    reset         = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({dbi.sig, dbi.rise, dbi.fall} !== 3'b000) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d sig/rise/fall got %b%b%b want 000", c, dbi.sig, dbi.rise, dbi.fall);
      end
    end
    reset = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if (dbi.sig !== (e >= 6) || dbi.rise !== (e == 6) || dbi.fall !== 1'b0) begin
        errors++;
        $display("FAIL reset_release edge=%0d sig/rise/fall got %b%b%b want %b%b0", e, dbi.sig, dbi.rise,
                 dbi.fall, (e >= 6), (e == 6));
      end
    end
  endtask

  task automatic test_glitch();
    go_low();
    for (int e = 1; e <= 12; e++) begin
      dbi.raw = (e <= 3);
      tick();
      checks++;
      if (dbi.sig !== 1'b0 || dbi.rise !== 1'b0 || dbi.fall !== 1'b0) begin
        errors++;
        $display("FAIL glitch edge=%0d sig/rise/fall got %b%b%b want 000", e, dbi.sig, dbi.rise, dbi.fall);
      end
    end
    // A clean step afterwards must take the full latency, showing the check was fully abandoned.
    dbi.raw = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if (dbi.sig !== (e >= 6) || dbi.rise !== (e == 6)) begin
        errors++;
        $display("FAIL glitch_recover edge=%0d sig/rise got %b%b want %b%b", e, dbi.sig, dbi.rise, (e >= 6), (e == 6));
      end
    end
  endtask

  task automatic test_clean_fall();
    dbi.raw       = 1'b1;
    dbi.sample_en = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    checks++;
    if (dbi.sig !== 1'b1) begin
      errors++;
      $display("FAIL fall_precond sig got %b want 1", dbi.sig);
    end
    dbi.raw = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      tick();
      checks++;
      if (dbi.sig !== (e < 6) || dbi.fall !== (e == 6) || dbi.rise !== 1'b0) begin
        errors++;
        $display("FAIL clean_fall edge=%0d sig/rise/fall got %b%b%b want %b0%b", e, dbi.sig, dbi.rise, dbi.fall,
                 (e < 6), (e == 6));
      end
    end
  endtask

  task automatic test_bounce();
    logic [4:0] pat;
    go_low();
    pat = 5'b10101;
    for (int e = 1; e <= 13; e++) begin
      dbi.raw = (e <= 5) ? pat[5-e] : 1'b1;
      tick();
      checks++;
      if (dbi.sig !== (e >= 10) || dbi.rise !== (e == 10) || dbi.fall !== 1'b0) begin
        errors++;
        $display("FAIL bounce edge=%0d sig/rise/fall got %b%b%b want %b%b0", e, dbi.sig, dbi.rise, dbi.fall,
                 (e >= 10), (e == 10));
      end
    end
  endtask

  task automatic test_strobe();
    go_low();
    dbi.raw = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      dbi.sample_en = (e % 2 == 0);
      tick();
      checks++;
      if (dbi.sig !== (e >= 10) || dbi.rise !== (e == 10) || dbi.fall !== 1'b0) begin
        errors++;
        $display("FAIL strobe edge=%0d sig/rise/fall got %b%b%b want %b%b0", e, dbi.sig, dbi.rise, dbi.fall,
                 (e >= 10), (e == 10));
      end
    end
    dbi.sample_en = 1'b1;
  endtask

  task automatic test_mid_reset();
    go_low();
    dbi.raw = 1'b1;
    // Edges 3..4 leave the check at count 2; reset lands on edge 5 and the step restarts from scratch.
    for (int e = 1; e <= 13; e++) begin
      reset = (e != 5);
      tick();
      checks++;
      if (dbi.sig !== (e >= 11) || dbi.rise !== (e == 11) || dbi.fall !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset edge=%0d sig/rise/fall got %b%b%b want %b%b0", e, dbi.sig, dbi.rise, dbi.fall,
                 (e >= 11), (e == 11));
      end
    end
    reset = 1'b1;
  endtask

  task automatic test_random();
    int hold;
    int n_rise;
    int n_fall;
    n_rise = 0;
    n_fall = 0;
    go_low();
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        dbi.raw = $urandom_range(0, 1);
        hold    = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 20) : $urandom_range(1, 4);
      end
      hold--;
      dbi.sample_en = ($urandom_range(0, 3) != 0);
      tick();
      n_rise += dbi.rise;
      n_fall += dbi.fall;
      checks++;
      if (dbi.sig !== m_sig || dbi.rise !== m_rise || dbi.fall !== m_fall) begin
        errors++;
        $display("FAIL random cyc=%0d sig/rise/fall got %b%b%b want %b%b%b", c, dbi.sig, dbi.rise, dbi.fall,
                 m_sig, m_rise, m_fall);
      end
      checks++;
      if ((dbi.rise & dbi.fall) !== 1'b0) begin
        errors++;
        $display("FAIL strobe_overlap cyc=%0d rise&fall got %b want 0", c, dbi.rise & dbi.fall);
      end
    end
    checks++;
    if (n_rise == 0 || n_fall == 0) begin
      errors++;
      $display("FAIL random_activity rises=%0d falls=%0d want both nonzero", n_rise, n_fall);
    end
  endtask

  // Model cross-check running underneath every directed scenario once reset has been applied.
  bit model_armed = 1'b0;
  always @(negedge clock) begin
    if (model_armed) begin
      checks++;
      if (dbi.sig !== m_sig || dbi.rise !== m_rise || dbi.fall !== m_fall) begin
        errors++;
        $display("FAIL model_track t=%0t sig/rise/fall got %b%b%b want %b%b%b", $time, dbi.sig, dbi.rise,
                 dbi.fall, m_sig, m_rise, m_fall);
      end
    end
  end

  initial begin
    dbi.raw       = 1'b0;
    dbi.sample_en = 1'b1;
    reset         = 1'b0;
    tick();
    model_armed = 1'b1;
    test_reset();
    test_glitch();
    test_clean_fall();
    test_bounce();
    test_strobe();
    test_mid_reset();
    test_random();
    model_armed = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
